// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned DataWidth = 16;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the requester not served last wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = M0;
    unique case (req)
      2'b01:   grant_idx = M0;
      2'b10:   grant_idx = M1;
      2'b11:   grant_idx = ~last_served;
      default: grant_idx = M0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (m0) and loader (m1) onto one data memory/IO port, one access per 3 cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 m0_req,
  input  logic                 m1_req,
  input  logic                 m0_write,
  input  logic                 m1_write,
  input  logic [DataWidth-1:0] m0_addr,
  input  logic [DataWidth-1:0] m1_addr,
  input  logic [DataWidth-1:0] m0_wdata,
  input  logic [DataWidth-1:0] m1_wdata,
  output logic                 m0_ack,
  output logic                 m1_ack,
  output logic [DataWidth-1:0] m0_rdata,
  output logic [DataWidth-1:0] m1_rdata,
  output logic [DataWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic                 mem_read,
  output logic                 mem_write,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 owner
);

  state_e               state_q, state_d;
  logic                 last_served_q;
  logic                 owner_q;
  logic                 cmd_write_q;
  logic [DataWidth-1:0] cmd_addr_q;
  logic [DataWidth-1:0] cmd_wdata_q;
  logic [DataWidth-1:0] m0_rdata_q;
  logic [DataWidth-1:0] m1_rdata_q;
  logic                 grant_valid;
  logic                 grant_idx;
  logic                 start;

  rr_arb2 u_rr_arb2 (
    .req         ({m1_req, m0_req}),
    .last_served (last_served_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign start = (state_q == StIdle) && grant_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant_valid) state_d = StAccess;
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      last_served_q <= M1;
      owner_q       <= M0;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        last_served_q <= grant_idx;
        owner_q       <= grant_idx;
        cmd_write_q   <= (grant_idx == M1) ? m1_write : m0_write;
        cmd_addr_q    <= (grant_idx == M1) ? m1_addr  : m0_addr;
        cmd_wdata_q   <= (grant_idx == M1) ? m1_wdata : m0_wdata;
      end
      if ((state_q == StAccess) && !cmd_write_q) begin
        if (owner_q == M1) m1_rdata_q <= mem_rdata;
        else               m0_rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state_q == StAccess) begin
      mem_addr  = cmd_addr_q;
      mem_wdata = cmd_wdata_q;
      mem_read  = !cmd_write_q;
      // Reset may land mid-access; the write must not commit at that edge.
      mem_write = cmd_write_q && reset_n;
    end
  end

  assign m0_ack   = (state_q == StDone) && (owner_q == M0);
  assign m1_ack   = (state_q == StDone) && (owner_q == M1);
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data memory and IO block.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        m0_req, m1_req, m0_write, m1_write;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic        owner;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic [7:0]  display;
  logic [1:0]  switches;

  typedef struct {
    logic        idx;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] done_rd [2];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;

  dmem_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_write  (m0_write),
    .m1_write  (m1_write),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_ack    (m0_ack),
    .m1_ack    (m1_ack),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory/IO block: switches at 0xfff0, display register at 0xfffa.
  assign mem_rdata = (mem_addr == 16'hfff0) ? {14'd0, switches} : mem[mem_addr[15:1]];

  always @(posedge clock) begin
    if (mem_write) begin
      if (mem_addr == 16'hfffa) display <= mem_wdata[7:0];
      else                      mem[mem_addr[15:1]] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mem_write) wr_cnt++;
    if (m0_ack || m1_ack) begin
      check_eq("ack_excl", {m1_ack, m0_ack}, (m1_ack ? 32'd2 : 32'd1));
      if (sb.size() == 0) begin
        check_eq("unexp_ack", {m1_ack, m0_ack}, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("ack_idx", {31'd0, m1_ack}, {31'd0, mon_e.idx});
        check_eq("owner", {31'd0, owner}, {31'd0, mon_e.idx});
        check_eq("rdata", mon_e.idx ? m1_rdata : m0_rdata, mon_e.rdata);
        check_eq("rdata_other", mon_e.idx ? m0_rdata : m1_rdata, done_rd[~mon_e.idx]);
        done_rd[mon_e.idx] = mon_e.rdata;
      end
    end
  end

  task automatic preload(input logic [15:0] addr, input logic [15:0] val);
    mem[addr[15:1]]     = val;
    ref_mem[addr[15:1]] = val;
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] addr);
    if (addr == 16'hfff0) return {14'd0, switches};
    return ref_mem[addr[15:1]];
  endfunction

  task automatic drive(input logic idx, input logic req, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (idx) begin
      m1_req = req; m1_write = wr; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_write = wr; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_acks"}, {m1_ack, m0_ack}, 0);
    check_eq({tag, "_owner"}, {31'd0, owner}, 0);
    check_eq({tag, "_rdata"}, {m1_rdata, m0_rdata}, 0);
    check_eq({tag, "_memctl"}, {mem_read, mem_write}, 0);
    check_eq({tag, "_membus"}, {mem_addr, mem_wdata}, 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) begin @(negedge clock); #1; end
    sb.delete();
    done_rd[0] = '0;
    done_rd[1] = '0;
  endtask

  // One access through the scoreboard; waits (bounded) for the ack, then drops req.
  task automatic run_access(input logic idx, input logic wr,
                            input logic [15:0] addr, input logic [15:0] wdata);
    exp_t e;
    int   n;
    e.idx = idx;
    if (wr) begin
      if (addr != 16'hfffa) ref_mem[addr[15:1]] = wdata;
      e.rdata = done_rd[idx];
    end else begin
      e.rdata = ref_read(addr);
    end
    sb.push_back(e);
    drive(idx, 1, wr, addr, wdata);
    n = 0;
    while (sb.size() != 0 && n < 10) begin @(negedge clock); #1; n++; end
    check_eq("ack_wait", sb.size(), 0);
    drive(idx, 0, 0, 0, 0);
    sb.delete();
    @(negedge clock); #1;
  endtask

  initial begin
    exp_t e;
    int   n;
    for (int i = 0; i < 32768; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    display  = '0;
    switches = 2'b00;
    preload(16'h0010, 16'h1234);
    preload(16'h0020, 16'h7777);
    apply_reset();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock); #1;

    // Single read: access in N+1, ack in N+2.
    e.idx = 1'b0; e.rdata = 16'h1234;
    sb.push_back(e);
    drive(0, 1, 0, 16'h0010, 16'h0);
    @(negedge clock); #1;
    check_eq("rd_access", {mem_read, mem_write, mem_addr}, {2'b10, 16'h0010});
    check_eq("rd_early_ack", {m1_ack, m0_ack}, 0);
    @(negedge clock); #1;
    check_eq("rd_ack", {m1_ack, m0_ack}, 1);
    check_eq("rd_memidle", {mem_read, mem_write}, 0);
    check_eq("rd_sb", sb.size(), 0);
    drive(0, 0, 0, 0, 0);
    sb.delete();
    @(negedge clock); #1;

    // Single write, then read-back.
    wr_cnt = 0;
    run_access(1, 1, 16'h0020, 16'hBEEF);
    check_eq("wr_pulses", wr_cnt, 1);
    check_eq("wr_mem", mem[16'h0020 >> 1], 16'hBEEF);
    run_access(0, 0, 16'h0020, 16'h0);

    // IO pass-through.
    run_access(0, 1, 16'hfffa, 16'h005B);
    check_eq("io_display", display, 8'h5B);
    switches = 2'b10;
    run_access(1, 0, 16'hfff0, 16'h0);
    check_eq("io_switch", m1_rdata, 16'h0002);

    // Contention from reset: both held for four accesses.
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      e.idx   = k[0];
      e.rdata = k[0] ? 16'hBEEF : 16'h1234;
      sb.push_back(e);
    end
    reset_n = 1'b1;
    drive(0, 1, 0, 16'h0010, 16'h0);
    drive(1, 1, 0, 16'h0020, 16'h0);
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clock); #1; n++; end
    check_eq("cont_sb", sb.size(), 0);
    check_eq("cont_cycles", n, 11);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    sb.delete();
    @(negedge clock); #1;

    // Reset during the ACCESS cycle of an m1 write.
    preload(16'h0030, 16'hA5A5);
    drive(1, 1, 1, 16'h0030, 16'h0000);
    @(negedge clock); #1;
    check_eq("rst_wr_access", {mem_write, mem_addr}, {1'b1, 16'h0030});
    reset_n = 1'b0;
    drive(1, 0, 0, 0, 0);
    #1;
    check_eq("rst_wr_gate", {31'd0, mem_write}, 0);
    @(negedge clock); #1;
    check_eq("rst_wr_mem", mem[16'h0030 >> 1], 16'hA5A5);
    check_reset_outputs("rst_mid");
    done_rd[0] = '0;
    done_rd[1] = '0;
    reset_n = 1'b1;
    @(negedge clock); #1;
    check_eq("rst_no_ack", {m1_ack, m0_ack}, 0);
    run_access(0, 0, 16'h0030, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
